// File: rtl/req_arb8.sv
// 8-way request arbiter with fixed-priority or round-robin selection,
// a bounded grant tenure (MAX_HOLD, 1..255 cycles) and registered grant outputs.
module req_arb8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout,
    output logic       fsm_state
);

    // Handshake: a grant is offered as gnt/gnt_id qualified by gnt_vld; the
    // owner ends it with a one-cycle done pulse, otherwise the tenure expires
    // after MAX_HOLD cycles and timeout pulses on the release edge.

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic [2:0] last_id;
    logic [2:0] last_nxt;
    logic [7:0] gnt_nxt;
    logic [2:0] gnt_id_nxt;
    logic       gnt_vld_nxt;
    logic       timeout_nxt;

    logic [2:0] win_fixed;
    logic [2:0] win_rr;
    logic [2:0] win;
    logic [2:0] idx;
    logic       grant_now;
    logic       hold_expired;

    assign fsm_state = state;

    // Winner selection; only consumed in IDLE, so mode is effectively sampled there.
    always_comb begin
        win_fixed = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) win_fixed = 3'(i);
        end
        // Iterate lowest priority first so the first bit in search order wins.
        win_rr = 3'd0;
        idx    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = last_id - 3'd1 - 3'(k);
            if (req[idx]) win_rr = idx;
        end
        win = mode ? win_rr : win_fixed;
    end

    assign grant_now    = (state == IDLE) && en && (req != 8'h00);
    assign hold_expired = (hold_cnt == HOLD_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_now) state_nxt = BUSY;
            BUSY: if (done || hold_expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and bookkeeping
    always_comb begin
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        gnt_vld_nxt = gnt_vld;
        timeout_nxt = 1'b0;
        hold_nxt    = hold_cnt;
        last_nxt    = last_id;
        case (state)
            IDLE: begin
                if (grant_now) begin
                    gnt_nxt     = 8'h01 << win;
                    gnt_id_nxt  = win;
                    gnt_vld_nxt = 1'b1;
                    hold_nxt    = 8'd0;
                    last_nxt    = win;
                end
            end
            BUSY: begin
                if (done || hold_expired) begin
                    // done has priority, so timeout only fires without it
                    gnt_nxt     = 8'h00;
                    gnt_vld_nxt = 1'b0;
                    hold_nxt    = 8'd0;
                    timeout_nxt = !done;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                gnt_nxt     = 8'h00;
                gnt_vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= 8'h00;
            gnt_id   <= 3'd0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
            last_id  <= 3'd0;
        end else begin
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            gnt_vld  <= gnt_vld_nxt;
            timeout  <= timeout_nxt;
            hold_cnt <= hold_nxt;
            last_id  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_req_arb8.sv
// Directed bench for req_arb8 with MAX_HOLD=4: fixed and round-robin
// selection, done/timeout release, enable gating and asynchronous reset.
module tb_req_arb8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;
    logic       fsm_state;

    int checks = 0;
    int errors = 0;

    req_arb8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_vld   (gnt_vld),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] id);
        chk({tag, "_gnt"}, gnt, g);
        chk({tag, "_id"}, {5'd0, gnt_id}, {5'd0, id});
        chk({tag, "_vld"}, {7'd0, gnt_vld}, 8'd1);
    endtask

    task automatic chk_idle(input string tag, input logic exp_tmo);
        chk({tag, "_gnt"}, gnt, 8'h00);
        chk({tag, "_vld"}, {7'd0, gnt_vld}, 8'd0);
        chk({tag, "_tmo"}, {7'd0, timeout}, {7'd0, exp_tmo});
    endtask

    logic [2:0] rr_exp [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #2;
        // Reset state
        chk_idle("rst", 1'b0);
        chk("rst_id", {5'd0, gnt_id}, 8'd0);
        chk("rst_state", {7'd0, fsm_state}, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Fixed priority, grant on the first edge after reset release
        en   = 1'b1;
        req  = 8'b0101_0100;
        tick();
        chk_grant("fix", 8'b0100_0000, 3'd6);
        chk("fix_state", {7'd0, fsm_state}, 8'd1);
        done = 1'b1;
        req  = 8'h00;
        tick();
        chk_idle("fix_rel", 1'b0);
        done = 1'b0;

        // Enable gating
        en  = 1'b0;
        req = 8'h81;
        tick();
        chk_idle("en0_a", 1'b0);
        tick();
        chk_idle("en0_b", 1'b0);
        en = 1'b1;
        tick();
        chk_grant("en1", 8'h80, 3'd7);
        done = 1'b1;
        tick();
        chk_idle("en1_rel", 1'b0);

        // done while IDLE is ignored: grant still issues
        req = 8'h04;
        tick();
        chk_grant("done_idle", 8'h04, 3'd2);
        req = 8'h00;
        tick();
        chk_idle("done_idle_rel", 1'b0);
        done = 1'b0;

        // Timeout after 4 cycles; req/mode/en changes must not disturb the grant
        req = 8'h04;
        tick();
        chk_grant("tmo_e0", 8'h04, 3'd2);
        req  = 8'hF0;
        mode = 1'b1;
        en   = 1'b0;
        tick();
        chk_grant("tmo_e1", 8'h04, 3'd2);
        chk("tmo_e1_tmo", {7'd0, timeout}, 8'd0);
        tick();
        chk_grant("tmo_e2", 8'h04, 3'd2);
        tick();
        chk_grant("tmo_e3", 8'h04, 3'd2);
        tick();
        chk_idle("tmo_e4", 1'b1);
        chk("tmo_e4_state", {7'd0, fsm_state}, 8'd0);
        tick();
        chk_idle("tmo_e5", 1'b0);

        // done in the 4th BUSY cycle beats the timeout
        mode = 1'b0;
        en   = 1'b1;
        req  = 8'h04;
        tick();
        chk_grant("dwin_e0", 8'h04, 3'd2);
        req = 8'h00;
        tick();
        tick();
        tick();
        chk_grant("dwin_e3", 8'h04, 3'd2);
        done = 1'b1;
        tick();
        chk_idle("dwin_e4", 1'b0);
        done = 1'b0;
        tick();
        chk_idle("dwin_e5", 1'b0);

        // Asynchronous reset mid-grant, then round-robin restarts from index 7
        req = 8'h10;
        tick();
        chk_grant("arst_pre", 8'h10, 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("arst", 1'b0);
        chk("arst_id", {5'd0, gnt_id}, 8'd0);
        #2;
        rst_n = 1'b1;
        mode = 1'b1;
        req  = 8'h03;
        tick();
        chk_grant("arst_rr", 8'h02, 3'd1);
        chk("arst_tmo", {7'd0, timeout}, 8'd0);
        done = 1'b1;
        tick();
        chk_idle("arst_rel", 1'b0);
        done = 1'b0;

        // Fresh reset, then round-robin rotation with req=FF
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_grant($sformatf("rr%0d", i), 8'h01 << rr_exp[i], rr_exp[i]);
            done = 1'b1;
            tick();
            chk_idle($sformatf("rr%0d_rel", i), 1'b0);
            done = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
